// File: rtl/cpu_fetch_unit_pkg.sv
// cpu_fetch_unit_pkg: shared widths, opcode encodings and fetch FSM states
package cpu_fetch_unit_pkg;
  localparam int OPCODE = 4;
  localparam int INSTR_W = 16;
  localparam int PC_W = 12;
  localparam logic [OPCODE-1:0] OP_NOP = 4'h0;
  localparam logic [OPCODE-1:0] LOADA = 4'h1;
  localparam logic [OPCODE-1:0] LOADB = 4'h2;
  localparam logic [OPCODE-1:0] STOREA = 4'h3;
  localparam logic [OPCODE-1:0] ALU_OP_ADD = 4'h4;
  localparam logic [OPCODE-1:0] ALU_OP_SUB = 4'h5;
  localparam logic [OPCODE-1:0] JUMP = 4'h6;
  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;
  typedef enum logic [1:0] {F_IDLE, F_REQ, F_WAIT, F_DONE} fetch_state_t;
endpackage

// File: rtl/cpu_fetch_unit_pc_reg.sv
// cpu_pc_reg: program counter with jump load taking priority over a wrapping increment
module cpu_pc_reg #(
  parameter int PC_W = 12,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            jump_en_i,
  input  logic [PC_W-1:0] jump_addr_i,
  input  logic            inc_en_i,
  output logic [PC_W-1:0] pc_o
);
  logic [PC_W-1:0] pc_q, pc_d;
  always_comb pc_d = jump_en_i ? jump_addr_i : inc_en_i ? pc_q + PC_W'(1) : pc_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  assign pc_o = pc_q;
endmodule

// File: rtl/cpu_fetch_unit.sv
// cpu_fetch_unit: owns PC and IR, fetches from imem via req/valid and stalls the controller
module cpu_fetch_unit #(
  parameter int INSTR_W = cpu_fetch_unit_pkg::INSTR_W,
  parameter int PC_W = cpu_fetch_unit_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int MAX_WAIT = 15
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          loadIR,
  input  logic                                          loadPC,
  input  logic                                          jump_en,
  input  logic [PC_W-1:0]                               jump_addr,
  output logic                                          imem_req,
  output logic [PC_W-1:0]                               imem_addr,
  input  logic [INSTR_W-1:0]                            imem_rdata,
  input  logic                                          imem_valid,
  output logic [cpu_fetch_unit_pkg::OPCODE-1:0]         opcode,
  output logic [INSTR_W-cpu_fetch_unit_pkg::OPCODE-1:0] operand,
  output logic [PC_W-1:0]                               pc,
  output logic                                          ir_valid,
  output logic                                          fetch_busy,
  output logic                                          fetch_err
);
  import cpu_fetch_unit_pkg::*;
  localparam int CW = $clog2(MAX_WAIT + 1);
  fetch_state_t state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0] addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic pc_inc_q, pc_inc_d, ir_valid_q, ir_valid_d, err_q, err_d, timeout;
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    pc_inc_d = pc_inc_q;
    ir_valid_d = ir_valid_q;
    err_d = err_q;
    timeout = cnt_q == CW'(MAX_WAIT - 1);
    case (state_q)
      F_IDLE: if (loadIR) begin
        state_d = F_REQ;
        pc_inc_d = loadPC;
        ir_valid_d = 1'b0;
      end
      F_REQ: begin
        state_d = F_WAIT;
        cnt_d = '0;
        addr_d = pc;
      end
      F_WAIT: if (imem_valid) begin
        ir_d = imem_rdata;
        state_d = F_DONE;
      end else if (timeout) begin
        ir_d = INSTR_W'(NOP_INSTR);
        err_d = 1'b1;
        state_d = F_DONE;
      end else cnt_d = cnt_q + CW'(1);
      F_DONE: begin
        ir_valid_d = 1'b1;
        state_d = F_IDLE;
      end
      default: state_d = F_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= F_IDLE;
      ir_q <= '0;
      addr_q <= RESET_PC;
      cnt_q <= '0;
      pc_inc_q <= 1'b0;
      ir_valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      pc_inc_q <= pc_inc_d;
      ir_valid_q <= ir_valid_d;
      err_q <= err_d;
    end
  cpu_pc_reg #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc (
    .clk(clk),
    .rst_n(rst_n),
    .jump_en_i(jump_en),
    .jump_addr_i(jump_addr),
    .inc_en_i(state_q == F_DONE && pc_inc_q),
    .pc_o(pc)
  );
  // the address is captured in F_REQ so a jump mid-fetch cannot disturb it
  assign imem_addr = state_q == F_REQ ? pc : addr_q;
  assign imem_req = state_q == F_REQ || state_q == F_WAIT;
  assign fetch_busy = imem_req;
  assign ir_valid = ir_valid_q || state_q == F_DONE;
  assign fetch_err = err_q;
  assign opcode = ir_q[INSTR_W-1 -: OPCODE];
  assign operand = ir_q[INSTR_W-OPCODE-1:0];
endmodule

// File: tb/tb_cpu_fetch_unit.sv
// tb_cpu_fetch_unit: directed tests of the fetch stage against a latency-programmable imem model
module tb_cpu_fetch_unit;
  import cpu_fetch_unit_pkg::*;
  logic clk = 0, rst_n = 0, loadIR = 0, loadPC = 0, jump_en = 0;
  logic [11:0] jump_addr = '0, imem_addr, operand, pc;
  logic [15:0] imem_rdata;
  logic [3:0] opcode;
  logic imem_req, imem_valid, ir_valid, fetch_busy, fetch_err;
  logic [15:0] mem [0:4095];
  int lat = 1, req_cnt = 0, checks = 0, errors = 0;

  cpu_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .loadIR(loadIR), .loadPC(loadPC), .jump_en(jump_en),
    .jump_addr(jump_addr), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .opcode(opcode), .operand(operand), .pc(pc), .ir_valid(ir_valid),
    .fetch_busy(fetch_busy), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;
  // req_cnt is 0 in the request cycle and n in the n-th wait cycle; lat=0 never answers
  always @(posedge clk) req_cnt <= imem_req ? req_cnt + 1 : 0;
  assign imem_valid = imem_req && lat != 0 && req_cnt == lat;
  assign imem_rdata = mem[imem_addr];

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0;
    loadIR = 0;
    loadPC = 0;
    jump_en = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic start_fetch(input logic inc);
    @(negedge clk);
    loadIR = 1;
    loadPC = inc;
    @(negedge clk);
    loadIR = 0;
    loadPC = 0;
  endtask

  task automatic wait_done(output int busy_cnt);
    busy_cnt = 0;
    for (int n = 0; n < 40 && !ir_valid; n++) begin
      if (fetch_busy) busy_cnt++;
      @(negedge clk);
    end
    checks++;
    if (ir_valid !== 1'b1) begin errors++; $display("FAIL wait_done: ir_valid=%b after 40 cycles, required 1", ir_valid); end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({imem_req, ir_valid, fetch_busy, fetch_err} !== 4'b0) begin errors++; $display("FAIL reset_flags: req/valid/busy/err=%b required 0000", {imem_req, ir_valid, fetch_busy, fetch_err}); end
    checks++;
    if ({opcode, operand} !== 16'h0) begin errors++; $display("FAIL reset_ir: got %h required 0000", {opcode, operand}); end
    checks++;
    if (pc !== 12'h000) begin errors++; $display("FAIL reset_pc: got %h required 000", pc); end
    rst_n = 1;
  endtask

  task automatic test_single_fetch();
    mem[0] = 16'h1ABC;
    lat = 1;
    start_fetch(1);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 12'h000 || fetch_busy !== 1'b1) begin errors++; $display("FAIL single_req: req=%b addr=%h busy=%b required 1 000 1", imem_req, imem_addr, fetch_busy); end
    repeat (2) @(negedge clk);
    checks++;
    if (opcode !== 4'h1 || operand !== 12'hABC) begin errors++; $display("FAIL single_ir: opcode=%h operand=%h required 1 abc", opcode, operand); end
    @(negedge clk);
    checks++;
    if (ir_valid !== 1'b1 || pc !== 12'h001 || fetch_busy !== 1'b0) begin errors++; $display("FAIL single_done: ir_valid=%b pc=%h busy=%b required 1 001 0", ir_valid, pc, fetch_busy); end
  endtask

  task automatic test_wait_states();
    int busy_cnt = 0;
    bit addr_ok = 1;
    mem[1] = 16'h2345;
    lat = 5;
    start_fetch(0);
    for (int n = 0; n < 40 && !ir_valid; n++) begin
      if (fetch_busy) busy_cnt++;
      if (imem_req && imem_addr !== 12'h001) addr_ok = 0;
      @(negedge clk);
    end
    checks++;
    if (busy_cnt != 6) begin errors++; $display("FAIL wait_busy: busy cycles=%0d required 6", busy_cnt); end
    checks++;
    if (!addr_ok) begin errors++; $display("FAIL wait_addr: imem_addr unstable, required 001"); end
    checks++;
    if ({opcode, operand} !== 16'h2345 || fetch_err !== 1'b0 || pc !== 12'h001) begin errors++; $display("FAIL wait_ir: ir=%h err=%b pc=%h required 2345 0 001", {opcode, operand}, fetch_err, pc); end
  endtask

  task automatic test_timeout();
    int busy_cnt;
    lat = 0;
    start_fetch(1);
    wait_done(busy_cnt);
    checks++;
    if (busy_cnt != 16) begin errors++; $display("FAIL timeout_busy: busy cycles=%0d required 16", busy_cnt); end
    checks++;
    if (fetch_err !== 1'b1 || {opcode, operand} !== 16'h0) begin errors++; $display("FAIL timeout_err: err=%b ir=%h required 1 0000", fetch_err, {opcode, operand}); end
    @(negedge clk);
    checks++;
    if (pc !== 12'h002 || ir_valid !== 1'b1) begin errors++; $display("FAIL timeout_pc: pc=%h ir_valid=%b required 002 1", pc, ir_valid); end
  endtask

  task automatic test_pc_wrap_jump();
    int busy_cnt;
    apply_reset();
    checks++;
    if (fetch_err !== 1'b0) begin errors++; $display("FAIL err_cleared: err=%b required 0", fetch_err); end
    jump_en = 1;
    jump_addr = 12'hFFF;
    @(negedge clk);
    jump_en = 0;
    checks++;
    if (pc !== 12'hFFF) begin errors++; $display("FAIL jump_idle: pc=%h required fff", pc); end
    mem[12'hFFF] = 16'h3111;
    lat = 1;
    start_fetch(1);
    wait_done(busy_cnt);
    @(negedge clk);
    checks++;
    if (pc !== 12'h000 || opcode !== 4'h3) begin errors++; $display("FAIL pc_wrap: pc=%h opcode=%h required 000 3", pc, opcode); end
    mem[0] = 16'h1ABC;
    start_fetch(1);
    wait_done(busy_cnt);
    jump_en = 1;
    jump_addr = 12'h123;
    @(negedge clk);
    jump_en = 0;
    checks++;
    if (pc !== 12'h123 || opcode !== 4'h1) begin errors++; $display("FAIL jump_done: pc=%h opcode=%h required 123 1", pc, opcode); end
    mem[12'h123] = 16'h4567;
    lat = 5;
    start_fetch(0);
    @(negedge clk);
    jump_en = 1;
    jump_addr = 12'h200;
    @(negedge clk);
    jump_en = 0;
    checks++;
    if (imem_addr !== 12'h123 || pc !== 12'h200) begin errors++; $display("FAIL jump_inflight: addr=%h pc=%h required 123 200", imem_addr, pc); end
    wait_done(busy_cnt);
    checks++;
    if ({opcode, operand} !== 16'h4567) begin errors++; $display("FAIL jump_inflight_ir: ir=%h required 4567", {opcode, operand}); end
  endtask

  task automatic test_busy_and_reset();
    int bursts = 0;
    logic prev = 0;
    mem[12'h200] = 16'h5AAA;
    lat = 5;
    start_fetch(0);
    if (imem_req && !prev) bursts++;
    prev = imem_req;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (imem_req && !prev) bursts++;
      prev = imem_req;
      loadIR = (i == 2);
    end
    checks++;
    if (bursts != 1 || {opcode, operand} !== 16'h5AAA || pc !== 12'h200) begin errors++; $display("FAIL busy_ignore: bursts=%0d ir=%h pc=%h required 1 5aaa 200", bursts, {opcode, operand}, pc); end
    lat = 0;
    start_fetch(1);
    repeat (2) @(negedge clk);
    #2 rst_n = 0;
    #1;
    checks++;
    if ({imem_req, fetch_busy, ir_valid} !== 3'b0 || {opcode, operand} !== 16'h0 || pc !== 12'h000) begin errors++; $display("FAIL async_reset: req/busy/valid=%b ir=%h pc=%h required 000 0000 000", {imem_req, fetch_busy, ir_valid}, {opcode, operand}, pc); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_op [3];
    int busy_cnt;
    exp_op[0] = LOADA;
    exp_op[1] = LOADB;
    exp_op[2] = ALU_OP_ADD;
    mem[0] = {LOADA, 12'h010};
    mem[1] = {LOADB, 12'h011};
    mem[2] = {ALU_OP_ADD, 12'h000};
    for (int i = 0; i < 3; i++) begin
      lat = i + 1;
      start_fetch(1);
      wait_done(busy_cnt);
      checks++;
      if (opcode !== exp_op[i]) begin errors++; $display("FAIL b2b_opcode[%0d]: got %h required %h", i, opcode, exp_op[i]); end
      @(negedge clk);
      checks++;
      if (pc !== 12'(i + 1)) begin errors++; $display("FAIL b2b_pc[%0d]: got %h required %h", i, pc, 12'(i + 1)); end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    test_reset();
    test_single_fetch();
    test_wait_states();
    test_timeout();
    test_pc_wrap_jump();
    test_busy_and_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cpu_fetch_unit.md
Name: cpu_fetch_unit

Overview:
Instruction-fetch stage directly upstream of the CPU controller. It owns the program counter (PC) and the instruction register (IR). It fetches instructions from instruction memory using a req/valid handshake and presents the opcode field to the controller's `opcode` input. The controller's `loadIR`/`loadPC` strobes start a fetch. `fetch_busy` tells the controller to hold its LOAD state until the IR is valid.

Parameters:
- INSTR_W, 16, instruction width; IR[15:12] is the opcode, IR[11:0] is the operand/address.
- PC_W, 12, PC width; the instruction-memory address space is 2**PC_W words.
- RESET_PC, 0, PC value after reset.
- MAX_WAIT, 15, maximum imem wait cycles before a fetch timeout.

Ports:
- clk, in, 1, single clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- loadIR, in, 1, controller strobe: start fetch at the current PC.
- loadPC, in, 1, controller strobe: advance the PC when the fetch completes.
- jump_en, in, 1, load the PC from jump_addr (higher priority than increment).
- jump_addr, in, PC_W, jump target.
- imem_req, out, 1, instruction-memory request.
- imem_addr, out, PC_W, fetch address.
- imem_rdata, in, INSTR_W, instruction data.
- imem_valid, in, 1, imem_rdata valid this cycle.
- opcode, out, OPCODE, IR[15:12], feeds the controller.
- operand, out, INSTR_W-OPCODE, IR[11:0].
- pc, out, PC_W, current PC.
- ir_valid, out, 1, IR holds a fresh instruction.
- fetch_busy, out, 1, fetch in progress; controller must stall.
- fetch_err, out, 1, sticky timeout flag.

Behaviour:
- **Reset** (rst_n low, async, any state):
  - PC = RESET_PC; IR = 0; state = F_IDLE.
  - imem_req, ir_valid, fetch_busy and fetch_err all 0.
  - opcode = 0 and operand = 0.
- **FSM states:** F_IDLE, F_REQ, F_WAIT, F_DONE.
- **F_IDLE:**
  - On loadIR=1: latch pc_inc = loadPC, go to F_REQ.
  - ir_valid clears on the same edge.
- **F_REQ (1 cycle):**
  - imem_req = 1, imem_addr = PC, fetch_busy = 1.
  - Next state F_WAIT; wait counter cleared.
- **F_WAIT:**
  - imem_req stays 1 and imem_addr stays stable; fetch_busy = 1.
  - If imem_valid: IR <= imem_rdata, go to F_DONE.
  - Else the counter increments. When the counter reaches MAX_WAIT: fetch_err <= 1, IR <= 0 (NOP encoding), go to F_DONE.
- **F_DONE (1 cycle):**
  - ir_valid = 1, fetch_busy = 0.
  - If pc_inc: PC <= PC+1, wrapping modulo 2**PC_W (0xFFF -> 0x000).
  - Next state F_IDLE. ir_valid stays high until the next loadIR.
- **Latency:**
  - With imem_valid in the first F_WAIT cycle, opcode updates 2 edges after loadIR is sampled.
  - ir_valid is high on the 3rd edge.
- **jump_en:**
  - Sampled in any state. PC <= jump_addr on the next edge and overrides a same-cycle increment in F_DONE.
  - A fetch already in flight completes with its old address; the jump affects the next fetch only.
- **loadIR while busy** (F_REQ/F_WAIT/F_DONE): ignored, with no queueing.
- **loadPC without loadIR:** ignored.
- **fetch_err:** sticky until reset.
- **Outputs:**
  - opcode and operand are driven combinationally from the IR register only, never from imem_rdata.
  - No X/Z is ever driven on any output.
- **imem_valid outside F_WAIT:** ignored.

Decomposition:
- Add to CPU_package:
  - INSTR_W and PC_W constants.
  - fetch_state_t enum {F_IDLE, F_REQ, F_WAIT, F_DONE}.
  - NOP_INSTR constant (0).
- Reuse the existing OPCODE width and opcode encodings from CPU_package.
- Natural sub-module: cpu_pc_reg, holding the PC register with reset, jump load, wrap increment and the jump>increment priority.
- The FSM, IR and wait counter stay in cpu_fetch_unit.

Test Plan:
- **Reset then single fetch:** release rst_n; loadIR=1, loadPC=1 for one cycle; imem returns 0x1ABC with 0 wait.
  - Required: imem_addr=0x000.
  - opcode=0x1 and operand=0xABC after 2 edges.
  - ir_valid=1 and pc=0x001.
- **Wait states:** imem_valid delayed 5 cycles.
  - Required: fetch_busy=1 for 6 cycles and imem_addr stable throughout.
  - IR captures the data; fetch_err=0.
- **Timeout:** imem_valid never asserts.
  - Required: after MAX_WAIT=15 wait cycles, fetch_err=1 and opcode=0.
  - ir_valid pulses into the hold state; PC increments when loadPC was set.
- **PC wrap and jump:**
  - jump_addr=0xFFF with jump_en=1, then fetch with loadPC -> pc=0x000.
  - jump_en asserted in the same cycle as F_DONE -> pc=jump_addr, not PC+1.
- **Busy and mid-operation reset:**
  - loadIR re-asserted during F_WAIT is ignored: only one imem_req burst.
  - rst_n dropped during F_WAIT immediately clears imem_req, fetch_busy and IR, and sets pc=RESET_PC asynchronously.
- **Back-to-back with the controller:** cpu_fetch_unit connected to the CPU controller, with imem holding LOADA, LOADB, then ADD.
  - Required: the controller sees opcodes LOADA, LOADB, ALU_OP_ADD in order.
  - PC steps 0->1->2->3.
